hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Pipeline hazard and forwarding controller for the five-stage core. It consumes the ID stage's source/destination/control outputs and shadows the destination, write-back and memory-read state of instructions as they move into EX and MEM. It drives `Freeze` back to IF/ID and registered forwarding selects to the EX-stage operand muxes. It also keeps a saturating stall-cycle counter for performance reporting.

## Interface
Parameters:
- `CNT_W`, 32: width of the stall-cycle counter.

Ports:
- `clk`, input, 1: core clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `src1`, input, 5: ID source register 1.
- `src2`, input, 5: ID source register 2; already 0 for immediate forms.
- `is_two_source`, input, 1: `src2` is a real operand.
- `id_dest`, input, 5: ID destination register.
- `id_wb_en`, input, 1: ID instruction writes the register file (pre-freeze value).
- `id_mem_read`, input, 1: ID instruction is a load.
- `branch_taken`, input, 1: EX resolved a taken branch this cycle; the ID instruction is squashed.
- `Freeze`, output, 1: hold IF/ID and inject a bubble into ID/EX.
- `sel_src1`, output, 2: EX operand-1 forwarding select.
- `sel_src2`, output, 2: EX operand-2 / store-data forwarding select.
- `stall_cnt`, output, CNT_W: number of cycles with `Freeze`=1.

## Operation
- Shadow entries: EX {dest, wb, mr} and MEM {dest, wb}. Every cycle MEM takes the EX entry's value, and EX takes the ID values.
- EX captures a bubble (wb=0, mr=0) when `Freeze`=1 or `branch_taken`=1.
- A source register "hits" a stage entry when src≠0, the stage's wb=1 and src==dest. `src2` is checked only if `is_two_source`=1.
- Register 0 never hits.
- Hazards against the WB stage are resolved by the register file (write-before-read), not by this unit.
- Select encoding: 00 = register file, 01 = MEM-stage ALU result, 10 = WB write value.
- Forwarding mode: see Configuration.
  - `Freeze` = (src1 hits EX, or src2 hits EX) AND EX.mr. This is a load-use hazard.
  - Next-cycle select: a hit on EX gives 01; otherwise a hit on MEM gives 10; otherwise 00. The nearer stage always wins.
- `branch_taken`=1 forces `Freeze`=0 and loads 00 into both selects.
- When `Freeze`=1, the selects load 00, because a bubble is entering EX.
- `stall_cnt` increments on each rising edge where `Freeze`=1. It saturates at all-ones.

## Timing
- Reset (`rst`=0, asynchronous) clears all shadow entries, `sel_src1`=`sel_src2`=00 and `stall_cnt`=0.
- Because shadows are cleared, `Freeze`=0 during and after reset.
- `Freeze` is combinational from the current ID inputs and the shadow state, with zero latency.
- The selects are registered. They are computed while an instruction is in ID and become valid on the edge where that instruction enters EX, so they have a latency of 1 cycle.
- A load-use hazard costs exactly one `Freeze` cycle. The next cycle the load sits in MEM, the hazard resolves as a MEM hit, and the select is 10.
- If `branch_taken` and a hazard occur in the same cycle, `branch_taken` wins: no freeze, a bubble is captured, and `stall_cnt` does not count.
- If both sources hit different stages, each select is resolved independently.
- Reset asserted mid-stall drops `Freeze` immediately.

## Configuration
- `HAZARD_FORWARDING_EN` defined:
  - forwarding behaviour as described above;
  - only load-use hazards stall.
- `HAZARD_FORWARDING_EN` undefined:
  - `Freeze` = src1 or src2 hits EX or MEM, regardless of mr;
  - `sel_src1`/`sel_src2` are held at 00;
  - the forwarding select logic is not built.
- All other behaviour, including flush, counter and reset, is identical in both builds.

## Structure
- Shared package `hazard_pkg`:
  - select encodings `FWD_RF`=2'b00, `FWD_MEM`=2'b01, `FWD_WB`=2'b10;
  - a stage-entry typedef {dest[4:0], wb, mr};
  - the bubble entry constant.
- One sub-module, `hazard_hit`: combinational (src, two_src_gate, entry) → hit. It is instantiated once per source/stage pair.
- Everything else stays in the top module.

## Test plan
- Reset, then hold `rst` low: `Freeze`=0, both selects 00, `stall_cnt`=0. After release, with no hazards, these stay unchanged.
- ALU r3←…, then next instruction uses src1=3 (forwarding build): no freeze; `sel_src1`=01 when the consumer is in EX. Add one unrelated instruction in between: `sel_src1`=10.
- Load r5, then next instruction uses src2=5 with `is_two_source`=1: `Freeze`=1 for 1 cycle, `stall_cnt`=1, and then `sel_src2`=10. Repeat with `is_two_source`=0: no freeze.
- Destination r0 with `wb_en`=1, then consumer of src1=0: no freeze, select 00.
- Load-use hazard coinciding with `branch_taken`=1: `Freeze`=0, selects 00, `stall_cnt` unchanged.
- Non-forwarding build, ALU r7 then consumer of r7: `Freeze`=1 for 2 cycles (EX then MEM hit), `stall_cnt`=2, selects stay 00. Preload the counter near all-ones and verify it saturates.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic [4:0] dest;
        logic       wb;
        logic       mr;
    } stage_entry_t;

    localparam stage_entry_t BUBBLE_ENTRY = '{dest: 5'd0, wb: 1'b0, mr: 1'b0};

    // Nearer stage wins: an EX hit shadows any MEM hit on the same source.
    function automatic logic [1:0] fwd_select(input logic ex_hit, input logic mem_hit);
        logic [1:0] sel;
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_hit.sv
// Source-vs-stage-entry hit detector; register 0 never hits.
module hazard_hit
    import hazard_pkg::*;
(
    input  logic [4:0]   i_src,
    input  logic         i_two_src_gate,
    input  stage_entry_t i_entry,
    output logic         o_hit
);

    logic w_unused_mr;

    assign w_unused_mr = i_entry.mr;
    assign o_hit = i_two_src_gate && (i_src != 5'd0) && i_entry.wb && (i_src == i_entry.dest);

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection, EX forwarding selects and stall counter for the five-stage core.
// Build option: HAZARD_FORWARDING_EN enables forwarding (only load-use stalls).
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       src1,
    input  logic [4:0]       src2,
    input  logic             is_two_source,
    input  logic [4:0]       id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic             branch_taken,
    output logic             Freeze,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_entry_t     r_ex;
    stage_entry_t     r_mem;
    stage_entry_t     w_ex_next;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_src1_ex_hit;
    logic w_src2_ex_hit;
    logic w_src1_mem_hit;
    logic w_src2_mem_hit;
    logic w_hazard;

    hazard_hit u_src1_ex (
        .i_src          (src1),
        .i_two_src_gate (1'b1),
        .i_entry        (r_ex),
        .o_hit          (w_src1_ex_hit)
    );

    hazard_hit u_src2_ex (
        .i_src          (src2),
        .i_two_src_gate (is_two_source),
        .i_entry        (r_ex),
        .o_hit          (w_src2_ex_hit)
    );

    hazard_hit u_src1_mem (
        .i_src          (src1),
        .i_two_src_gate (1'b1),
        .i_entry        (r_mem),
        .o_hit          (w_src1_mem_hit)
    );

    hazard_hit u_src2_mem (
        .i_src          (src2),
        .i_two_src_gate (is_two_source),
        .i_entry        (r_mem),
        .o_hit          (w_src2_mem_hit)
    );

`ifdef HAZARD_FORWARDING_EN
    assign w_hazard = (w_src1_ex_hit || w_src2_ex_hit) && r_ex.mr;
`else
    assign w_hazard = w_src1_ex_hit || w_src2_ex_hit || w_src1_mem_hit || w_src2_mem_hit;
`endif

    // A taken branch squashes the ID instruction, so its hazard is moot.
    assign Freeze = w_hazard && !branch_taken;

    always_comb begin
        w_ex_next = BUBBLE_ENTRY;
        if (!Freeze && !branch_taken) begin
            w_ex_next.dest = id_dest;
            w_ex_next.wb   = id_wb_en;
            w_ex_next.mr   = id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex  <= BUBBLE_ENTRY;
            r_mem <= BUBBLE_ENTRY;
        end else begin
            r_ex  <= w_ex_next;
            r_mem <= r_ex;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (Freeze && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign stall_cnt = r_stall_cnt;

`ifdef HAZARD_FORWARDING_EN
    logic [1:0] r_sel_src1;
    logic [1:0] r_sel_src2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel_src1 <= FWD_RF;
            r_sel_src2 <= FWD_RF;
        end else if (Freeze || branch_taken) begin
            r_sel_src1 <= FWD_RF;
            r_sel_src2 <= FWD_RF;
        end else begin
            r_sel_src1 <= fwd_select(w_src1_ex_hit, w_src1_mem_hit);
            r_sel_src2 <= fwd_select(w_src2_ex_hit, w_src2_mem_hit);
        end
    end

    assign sel_src1 = r_sel_src1;
    assign sel_src2 = r_sel_src2;
`else
    assign sel_src1 = FWD_RF;
    assign sel_src2 = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit; follows HAZARD_FORWARDING_EN when defined.
module tb_hazard_forward_unit;

    localparam int CW = 4;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    src1 = '0;
    logic [4:0]    src2 = '0;
    logic          is_two_source = 1'b0;
    logic [4:0]    id_dest = '0;
    logic          id_wb_en = 1'b0;
    logic          id_mem_read = 1'b0;
    logic          branch_taken = 1'b0;
    logic          Freeze;
    logic [1:0]    sel_src1;
    logic [1:0]    sel_src2;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]    s1;
        logic [1:0]    s2;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [4:0]    m_ex_d, m_mem_d;
    logic          m_ex_wb, m_ex_mr, m_mem_wb;
    logic [CW-1:0] m_cnt;

    always #5 clk = ~clk;

    hazard_forward_unit #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .src1          (src1),
        .src2          (src2),
        .is_two_source (is_two_source),
        .id_dest       (id_dest),
        .id_wb_en      (id_wb_en),
        .id_mem_read   (id_mem_read),
        .branch_taken  (branch_taken),
        .Freeze        (Freeze),
        .sel_src1      (sel_src1),
        .sel_src2      (sel_src2),
        .stall_cnt     (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic mhit(input logic [4:0] s, input logic g, input logic [4:0] d, input logic w);
        return g && (s != 5'd0) && w && (s == d);
    endfunction

    task automatic model_reset();
        m_ex_d = '0; m_ex_wb = 1'b0; m_ex_mr = 1'b0;
        m_mem_d = '0; m_mem_wb = 1'b0;
        m_cnt = '0;
        sb.delete();
    endtask

    // One ID cycle: drive, check Freeze, predict the registered outputs, clock, compare.
    task automatic step(input logic [4:0] a, input logic [4:0] b, input logic two,
                        input logic [4:0] d, input logic wb, input logic mr,
                        input logic bt, output logic frz);
        logic h1e, h2e, h1m, h2m;
        exp_t e;
        src1 = a; src2 = b; is_two_source = two;
        id_dest = d; id_wb_en = wb; id_mem_read = mr; branch_taken = bt;
        #1;
        h1e = mhit(a, 1'b1, m_ex_d, m_ex_wb);
        h2e = mhit(b, two, m_ex_d, m_ex_wb);
        h1m = mhit(a, 1'b1, m_mem_d, m_mem_wb);
        h2m = mhit(b, two, m_mem_d, m_mem_wb);
        if (FWD) frz = (h1e || h2e) && m_ex_mr && !bt;
        else     frz = (h1e || h2e || h1m || h2m) && !bt;
        chk("freeze", {31'd0, Freeze}, {31'd0, frz});
        e.s1 = 2'b00;
        e.s2 = 2'b00;
        if (FWD && !frz && !bt) begin
            e.s1 = h1e ? 2'b01 : (h1m ? 2'b10 : 2'b00);
            e.s2 = h2e ? 2'b01 : (h2m ? 2'b10 : 2'b00);
        end
        e.cnt = (frz && (m_cnt != '1)) ? m_cnt + 1'b1 : m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        m_mem_d = m_ex_d; m_mem_wb = m_ex_wb;
        if (frz || bt) begin
            m_ex_d = '0; m_ex_wb = 1'b0; m_ex_mr = 1'b0;
        end else begin
            m_ex_d = d; m_ex_wb = wb; m_ex_mr = mr;
        end
        m_cnt = e.cnt;
        e = sb.pop_front();
        chk("sel_src1", {30'd0, sel_src1}, {30'd0, e.s1});
        chk("sel_src2", {30'd0, sel_src2}, {30'd0, e.s2});
        chk("stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, {{(32-CW){1'b0}}, e.cnt});
    endtask

    // Issue one instruction, holding it in ID while frozen (bounded).
    task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic two,
                         input logic [4:0] d, input logic wb, input logic mr, input logic bt);
        logic f;
        int n;
        n = 0;
        do begin
            step(a, b, two, d, wb, mr, bt, f);
            n++;
        end while (f && n < 4);
        if (f) begin
            n_errors++;
            $display("FAIL freeze_bound still frozen after %0d cycles", n);
        end
    endtask

    task automatic nop();
        issue(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset held with hazard-looking inputs: shadows are clear, no freeze.
        src1 = 5'd3; id_dest = 5'd3; id_wb_en = 1'b1; id_mem_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_freeze", {31'd0, Freeze}, 32'd0);
            chk("rst_sel1", {30'd0, sel_src1}, 32'd0);
            chk("rst_sel2", {30'd0, sel_src2}, 32'd0);
            chk("rst_cnt", {{(32-CW){1'b0}}, stall_cnt}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) nop();

        // ALU r3 then consumer, then with one unrelated instruction between.
        issue(5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        issue(5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        nop(); nop(); nop();
        issue(5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        issue(5'd1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        issue(5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        nop(); nop(); nop();

        // Load r5, consumer on src2 with and without is_two_source.
        issue(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        issue(5'd0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        nop(); nop(); nop();
        issue(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        issue(5'd0, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        nop(); nop(); nop();

        // Writes to r0 never forward.
        issue(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        issue(5'd0, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        nop(); nop(); nop();

        // Load-use coinciding with a taken branch.
        issue(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        issue(5'd5, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
        nop(); nop(); nop();

        // Two sources hitting different stages; also ALU r7 then r7 consumer.
        issue(5'd0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        issue(5'd0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        issue(5'd2, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        nop(); nop(); nop();
        issue(5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        issue(5'd7, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        nop(); nop(); nop();

        // Drive the narrow counter to saturation.
        for (int i = 0; i < 20; i++) begin
            issue(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
            issue(5'd5, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        end
        nop(); nop();

        // Reset asserted mid-stall drops Freeze at once.
        issue(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        src1 = 5'd5; src2 = 5'd0; is_two_source = 1'b0;
        id_dest = 5'd6; id_wb_en = 1'b1; id_mem_read = 1'b0; branch_taken = 1'b0;
        #1;
        chk("midstall_pre", {31'd0, Freeze}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midstall_freeze", {31'd0, Freeze}, 32'd0);
        chk("midstall_sel1", {30'd0, sel_src1}, 32'd0);
        chk("midstall_cnt", {{(32-CW){1'b0}}, stall_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        nop(); nop();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
